// File: rtl/nios_pio_dbuf_if.sv
// nios_pio_dbuf_if: Avalon-MM slave bus bundle for the double-buffered output PIO.
//   address     4-bit word address
//   chipselect  slave select
//   write_n     write strobe, active low
//   writedata   32-bit write data
//   readdata    32-bit read data, driven combinationally by the slave
// Modports: master (CPU / fabric side), slave (PIO side).
interface nios_pio_dbuf_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_pio_dbuf.sv
// nios_pio_dbuf: multi-channel Avalon-MM output PIO with shadow registers.
// CPU writes land in shadow registers; all channels are copied to the active set in one
// clock on a frame_sync rising edge (when something is pending) or on a FORCE write, so
// the video side never observes a partially updated set of channels.
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   bus         Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   frame_sync  frame strobe, synchronous to clk
//   out_port    active channels, ch i at [i*WIDTH +: WIDTH]
//   irq         commit interrupt, level, active high
// Register map (word address): 0..7 SHADOW, 8 CTRL {PENDING, IRQ_EN, FORCE},
//   9 STATUS {IRQ_FLAG, W1C}, 10 COUNT (16-bit commit counter), others read 0.
module nios_pio_dbuf #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 10,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    nios_pio_dbuf_if.slave          bus,
    input  logic                    frame_sync,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    output logic                    irq
);

    localparam logic [3:0]       AddrCtrl   = 4'd8;
    localparam logic [3:0]       AddrStatus = 4'd9;
    localparam logic [3:0]       AddrCount  = 4'd10;
    localparam logic [WIDTH-1:0] ResetVal   = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] shadow_q [NUM_CH];
    logic [WIDTH-1:0] shadow_d [NUM_CH];
    logic [WIDTH-1:0] active_q [NUM_CH];
    logic [WIDTH-1:0] active_d [NUM_CH];
    logic             pending_q, pending_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_flag_q, irq_flag_d;
    logic [15:0]      count_q, count_d;
    logic             sync_d_q;

    logic wr;
    logic sync_rise;
    logic force_wr;
    logic commit;
    logic shadow_wr;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign sync_rise = frame_sync & ~sync_d_q;
    assign force_wr  = wr & (bus.address == AddrCtrl) & bus.writedata[0];
    assign commit    = (sync_rise & pending_q) | force_wr;

    // Shadow writes; addresses at or above NUM_CH match no channel and are dropped.
    always_comb begin
        shadow_d  = shadow_q;
        shadow_wr = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && (bus.address == 4'(i))) begin
                shadow_d[i] = bus.writedata[WIDTH-1:0];
                shadow_wr   = 1'b1;
            end
        end
    end

    // Commit copies the pre-write shadow values; a shadow write in the same cycle is held
    // back for the next commit, so pending is re-armed by it.
    always_comb begin
        active_d = active_q;
        count_d  = count_q;
        if (commit) begin
            active_d = shadow_q;
            count_d  = count_q + 16'd1;
        end
        pending_d = (pending_q & ~commit) | shadow_wr;
    end

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && (bus.address == AddrCtrl)) begin
            irq_en_d = bus.writedata[1];
        end
        irq_flag_d = irq_flag_q;
        if (wr && (bus.address == AddrStatus) && bus.writedata[0]) begin
            irq_flag_d = 1'b0;
        end
        // Set has priority over a simultaneous W1C.
        if (commit) begin
            irq_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= ResetVal;
                active_q[i] <= ResetVal;
            end
            pending_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_flag_q <= 1'b0;
            count_q    <= 16'd0;
            sync_d_q   <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            irq_en_q   <= irq_en_d;
            irq_flag_q <= irq_flag_d;
            count_q    <= count_d;
            sync_d_q   <= frame_sync;
        end
    end

    // Combinational, side-effect-free read mux; FORCE always reads back as 0.
    always_comb begin
        bus.readdata = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.address == 4'(i)) begin
                bus.readdata[WIDTH-1:0] = shadow_q[i];
            end
        end
        case (bus.address)
            AddrCtrl:   bus.readdata[2:0]  = {pending_q, irq_en_q, 1'b0};
            AddrStatus: bus.readdata[0]    = irq_flag_q;
            AddrCount:  bus.readdata[15:0] = count_q;
            default:    ;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*WIDTH +: WIDTH] = active_q[g];
    end

    assign irq = irq_flag_q & irq_en_q;

endmodule

// File: tb/tb_nios_pio_dbuf.sv
// tb_nios_pio_dbuf: directed plus randomized bench for nios_pio_dbuf (NUM_CH=4, WIDTH=10)
// against a transaction-level reference model of the register file.
module tb_nios_pio_dbuf;

    localparam int NumCh = 4;
    localparam int Width = 10;

    logic                   clk;
    logic                   reset_n;
    logic                   frame_sync;
    logic [NumCh*Width-1:0] out_port;
    logic                   irq;

    nios_pio_dbuf_if bus ();

    nios_pio_dbuf #(
        .NUM_CH    (NumCh),
        .WIDTH     (Width),
        .RESET_VAL (32'd0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .frame_sync (frame_sync),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [Width-1:0] m_shadow [NumCh];
    logic [Width-1:0] m_active [NumCh];
    bit               m_pending;
    bit               m_irq_en;
    bit               m_irq_flag;
    bit               m_fs_prev;
    int               m_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NumCh; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_pending  = 0;
        m_irq_en   = 0;
        m_irq_flag = 0;
        m_fs_prev  = 0;
        m_count    = 0;
    endtask

    // One clock of the register file, from the bus/frame_sync inputs at the edge.
    task automatic model_clock();
        bit          wr;
        bit          do_commit;
        int          a;
        logic [31:0] wd;
        wr        = bus.chipselect && !bus.write_n;
        a         = int'(bus.address);
        wd        = bus.writedata;
        do_commit = (frame_sync && !m_fs_prev && m_pending) || (wr && a == 8 && wd[0]);
        if (do_commit) begin
            for (int i = 0; i < NumCh; i++) m_active[i] = m_shadow[i];
            m_count   = (m_count + 1) % 65536;
            m_pending = 0;
        end
        if (wr && a < NumCh) begin
            m_shadow[a] = wd[Width-1:0];
            m_pending   = 1;
        end
        if (wr && a == 8) m_irq_en = wd[1];
        if (wr && a == 9 && wd[0]) m_irq_flag = 0;
        if (do_commit) m_irq_flag = 1;
        m_fs_prev = frame_sync;
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r;
        r = 32'd0;
        if (a < NumCh) r = 32'(m_shadow[a]);
        else if (a == 8) r = {29'd0, m_pending, m_irq_en, 1'b0};
        else if (a == 9) r = {31'd0, m_irq_flag};
        else if (a == 10) r = m_count[31:0];
        return r;
    endfunction

    function automatic logic [NumCh*Width-1:0] model_out();
        logic [NumCh*Width-1:0] v;
        for (int i = 0; i < NumCh; i++) v[i*Width +: Width] = m_active[i];
        return v;
    endfunction

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 4'd0;
        bus.writedata  = 32'd0;
    endtask

    task automatic set_write(input int a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 4'(a);
        bus.writedata  = d;
    endtask

    // Advance one clock and compare the registered outputs just after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_eq({tag, ".out_port"}, 64'(out_port), 64'(model_out()));
        check_eq({tag, ".irq"}, 64'(irq), 64'(m_irq_flag && m_irq_en));
    endtask

    task automatic bus_write(input int a, input logic [31:0] d, input string tag);
        set_write(a, d);
        step(tag);
        bus_idle();
    endtask

    task automatic check_read(input int a, input string tag);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 4'(a);
        #1;
        check_eq(tag, 64'(bus.readdata), 64'(model_read(a)));
        bus_idle();
    endtask

    task automatic sync_pulse(input string tag);
        frame_sync = 1'b1;
        step(tag);
        frame_sync = 1'b0;
        step(tag);
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_sync = 1'b0;
        bus_idle();
        model_reset();
        #12;
        check_eq("reset.out_port", 64'(out_port), 64'd0);
        check_eq("reset.irq", 64'(irq), 64'd0);
        check_read(10, "reset.count");
        check_read(8, "reset.ctrl");
        reset_n = 1'b1;

        // Buffered multi-channel update applied on frame sync.
        bus_write(0, 32'h155, "t2.wr0");
        bus_write(1, 32'h2AA, "t2.wr1");
        check_read(8, "t2.pending_set");
        check_read(1, "t2.shadow1");
        sync_pulse("t2.commit");
        check_eq("t2.ch0", 64'(out_port[9:0]), 64'h155);
        check_eq("t2.ch1", 64'(out_port[19:10]), 64'h2AA);
        check_read(10, "t2.count");
        check_read(8, "t2.pending_clr");

        // Frame sync with nothing pending, and frame_sync held high for several cycles.
        sync_pulse("t3.idle_sync");
        check_read(10, "t3.count");
        check_read(9, "t3.flag");
        bus_write(3, 32'h0AB, "t3.wr3");
        frame_sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) set_write(3, 32'h0CD);
            step("t3.held");
            bus_idle();
        end
        frame_sync = 1'b0;
        step("t3.held_low");
        check_read(8, "t3.held_pending");

        // Shadow write colliding with the commit edge.
        bus_write(0, 32'h011, "t4.wr0");
        frame_sync = 1'b1;
        set_write(2, 32'h3FF);
        step("t4.collide");
        bus_idle();
        frame_sync = 1'b0;
        check_read(8, "t4.pending");
        step("t4.low");
        sync_pulse("t4.second");
        check_eq("t4.ch2", 64'(out_port[29:20]), 64'h3FF);

        // Interrupt enable, W1C, and W1C losing against a commit.
        bus_write(8, 32'h2, "t5.irq_en");
        bus_write(1, 32'h001, "t5.wr1");
        sync_pulse("t5.commit");
        check_eq("t5.irq_on", 64'(irq), 64'd1);
        bus_write(9, 32'h1, "t5.w1c");
        check_eq("t5.irq_off", 64'(irq), 64'd0);
        bus_write(1, 32'h002, "t5.wr1b");
        frame_sync = 1'b1;
        set_write(9, 32'h1);
        step("t5.w1c_vs_commit");
        bus_idle();
        frame_sync = 1'b0;
        check_eq("t5.irq_stays", 64'(irq), 64'd1);
        step("t5.low");

        // FORCE coinciding with sync_rise: a single commit.
        bus_write(2, 32'h155, "t6.wr2");
        frame_sync = 1'b1;
        set_write(8, 32'h3);
        step("t6.force_sync");
        bus_idle();
        frame_sync = 1'b0;
        check_read(10, "t6.count_once");
        check_read(8, "t6.ctrl");
        step("t6.low");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int a;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) frame_sync = ~frame_sync;
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = 1'($urandom_range(0, 2) == 0);
            bus.address    = 4'(a);
            bus.writedata  = $urandom;
            #1;
            check_eq("rand.read", 64'(bus.readdata), 64'(model_read(a)));
            step("rand");
        end
        bus_idle();
        frame_sync = 1'b0;
        step("rand.end");

        // Reset asserted while data is pending.
        bus_write(0, 32'h123, "t6.pend_wr");
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6.rst_out", 64'(out_port), 64'd0);
        check_read(8, "t6.rst_ctrl");
        check_read(0, "t6.rst_shadow0");
        check_read(10, "t6.rst_count");
        reset_n = 1'b1;

        // Counter wrap: 65535 back-to-back FORCE commits, then one more.
        set_write(8, 32'h1);
        for (int n = 0; n < 65535; n++) step("t6.force_loop");
        bus_idle();
        check_read(10, "t6.count_ffff");
        check_eq("t6.count_ffff_abs", 64'(m_count), 64'hFFFF);
        bus_write(8, 32'h1, "t6.force_wrap");
        check_read(10, "t6.count_wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
